// File: rtl/gps_signal_gen_if.sv
// Control and sample-stream bundle for the synthetic GPS L1 C/A source.
// The master side drives the controls; the slave side is the generator itself.
interface gps_signal_gen_if;
    logic        start;
    logic        stop;
    logic [5:0]  prn;
    logic [9:0]  init_chip_delay;
    logic [15:0] doppler_omega;
    logic        nav_bit;

    logic        adc_clk;
    logic        i_sample;
    logic        q_sample;
    logic        busy;
    logic        code_epoch;
    logic        data_req;
    logic [12:0] sample_count;

    modport master (
        output start, stop, prn, init_chip_delay, doppler_omega, nav_bit,
        input  adc_clk, i_sample, q_sample, busy, code_epoch, data_req, sample_count
    );

    modport slave (
        input  start, stop, prn, init_chip_delay, doppler_omega, nav_bit,
        output adc_clk, i_sample, q_sample, busy, code_epoch, data_req, sample_count
    );
endinterface

// File: rtl/gps_signal_gen.sv
// Synthetic GPS L1 C/A baseband source: 1-bit I/Q samples plus a divided sample clock,
// carrying a selected PRN, an initial code phase, carrier Doppler rotation and nav data.
module gps_signal_gen #(
    parameter int unsigned CLK_DIV        = 8,
    parameter int unsigned CODE_NCO_OMEGA = 131,
    parameter int unsigned BURST_LEN      = 4096,
    parameter int unsigned EPOCHS_PER_BIT = 20
) (
    input logic             clk,
    input logic             rst,
    gps_signal_gen_if.slave bus
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned EPOCH_W = $clog2(EPOCHS_PER_BIT + 1);
    localparam logic [DIV_W-1:0]   DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_MAX = EPOCH_W'(EPOCHS_PER_BIT);
    localparam logic [9:0]         LAST_CHIP = 10'd1022;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    // G2 phase-select taps per PRN, returned as a one-hot-pair mask; invalid PRNs give 0.
    function automatic logic [10:1] tap_mask(input logic [5:0] p);
        logic [7:0]  t;
        logic [10:1] m;
        case (p)
            6'd1:    t = {4'd2, 4'd6};
            6'd2:    t = {4'd3, 4'd7};
            6'd3:    t = {4'd4, 4'd8};
            6'd4:    t = {4'd5, 4'd9};
            6'd5:    t = {4'd1, 4'd9};
            6'd6:    t = {4'd2, 4'd10};
            6'd7:    t = {4'd1, 4'd8};
            6'd8:    t = {4'd2, 4'd9};
            6'd9:    t = {4'd3, 4'd10};
            6'd10:   t = {4'd2, 4'd3};
            6'd11:   t = {4'd3, 4'd4};
            6'd12:   t = {4'd5, 4'd6};
            6'd13:   t = {4'd6, 4'd7};
            6'd14:   t = {4'd7, 4'd8};
            6'd15:   t = {4'd8, 4'd9};
            6'd16:   t = {4'd9, 4'd10};
            6'd17:   t = {4'd1, 4'd4};
            6'd18:   t = {4'd2, 4'd5};
            6'd19:   t = {4'd3, 4'd6};
            6'd20:   t = {4'd4, 4'd7};
            6'd21:   t = {4'd5, 4'd8};
            6'd22:   t = {4'd6, 4'd9};
            6'd23:   t = {4'd1, 4'd3};
            6'd24:   t = {4'd4, 4'd6};
            6'd25:   t = {4'd5, 4'd7};
            6'd26:   t = {4'd6, 4'd8};
            6'd27:   t = {4'd7, 4'd9};
            6'd28:   t = {4'd8, 4'd10};
            6'd29:   t = {4'd1, 4'd6};
            6'd30:   t = {4'd2, 4'd7};
            6'd31:   t = {4'd3, 4'd8};
            6'd32:   t = {4'd4, 4'd9};
            default: t = 8'd0;
        endcase
        for (int k = 1; k <= 10; k++) begin
            m[k] = (4'(k) == t[7:4]) || (4'(k) == t[3:0]);
        end
        return m;
    endfunction

    state_e             state_q;
    logic [10:1]        g1_q;
    logic [10:1]        g2_q;
    logic [10:1]        tap_mask_q;
    logic [8:0]         code_nco_q;
    logic [15:0]        phase_q;
    logic [9:0]         chip_cnt_q;
    logic [9:0]         load_rem_q;
    logic [EPOCH_W-1:0] epoch_cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic               data_q;
    logic               adc_clk_q;
    logic               i_q;
    logic               q_q;
    logic               busy_q;
    logic               code_epoch_q;
    logic               data_req_q;
    logic [12:0]        sample_count_q;

    logic [9:0]         nco_sum;
    logic               carry;
    logic               chip;
    logic               cos_bit;
    logic               sin_bit;
    logic               tick;
    logic               burst_end;
    logic [10:1]        g1_next;
    logic [10:1]        g2_next;
    logic [12:0]        sc_inc;
    logic [EPOCH_W-1:0] epoch_inc;
    logic [9:0]         delay_sat;

    always_comb begin
        nco_sum   = {1'b0, code_nco_q} + 10'(CODE_NCO_OMEGA);
        carry     = nco_sum[9];
        chip      = (|tap_mask_q) & (g1_q[10] ^ (^(g2_q & tap_mask_q)));
        cos_bit   = phase_q[15] ^ phase_q[14];
        sin_bit   = phase_q[15];
        tick      = (state_q == StRun) && (div_q == DIV_HALF);
        sc_inc    = sample_count_q + 13'd1;
        burst_end = (BURST_LEN != 0) && (sc_inc == 13'(BURST_LEN));
        epoch_inc = epoch_cnt_q + EPOCH_W'(1);
        g1_next   = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
        g2_next   = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
        delay_sat = (bus.init_chip_delay > LAST_CHIP) ? LAST_CHIP : bus.init_chip_delay;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            g1_q           <= '1;
            g2_q           <= '1;
            tap_mask_q     <= '0;
            code_nco_q     <= '0;
            phase_q        <= '0;
            chip_cnt_q     <= '0;
            load_rem_q     <= '0;
            epoch_cnt_q    <= '0;
            div_q          <= '0;
            data_q         <= 1'b0;
            adc_clk_q      <= 1'b0;
            i_q            <= 1'b0;
            q_q            <= 1'b0;
            busy_q         <= 1'b0;
            code_epoch_q   <= 1'b0;
            data_req_q     <= 1'b0;
            sample_count_q <= '0;
        end else begin
            code_epoch_q <= 1'b0;
            data_req_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    adc_clk_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (bus.start) begin
                        g1_q           <= '1;
                        g2_q           <= '1;
                        tap_mask_q     <= tap_mask(bus.prn);
                        code_nco_q     <= '0;
                        phase_q        <= '0;
                        chip_cnt_q     <= '0;
                        epoch_cnt_q    <= '0;
                        div_q          <= '0;
                        sample_count_q <= '0;
                        load_rem_q     <= delay_sat;
                        data_q         <= bus.nav_bit;
                        busy_q         <= 1'b1;
                        state_q        <= StLoad;
                    end
                end
                StLoad: begin
                    if (bus.stop) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        adc_clk_q <= 1'b0;
                    end else begin
                        if (load_rem_q != 10'd0) begin
                            g1_q       <= g1_next;
                            g2_q       <= g2_next;
                            chip_cnt_q <= chip_cnt_q + 10'd1;
                            load_rem_q <= load_rem_q - 10'd1;
                        end
                        // Last advance and the RUN transition share a clk; delay 0 still costs one.
                        if (load_rem_q <= 10'd1) begin
                            state_q <= StRun;
                            div_q   <= '0;
                        end
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        adc_clk_q <= 1'b0;
                    end else begin
                        div_q     <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                        adc_clk_q <= (div_q < DIV_HALF);
                        if (tick) begin
                            i_q            <= chip ^ data_q ^ cos_bit;
                            q_q            <= chip ^ data_q ^ sin_bit;
                            phase_q        <= phase_q + bus.doppler_omega;
                            code_nco_q     <= nco_sum[8:0];
                            sample_count_q <= sc_inc;
                            if (carry) begin
                                g1_q <= g1_next;
                                g2_q <= g2_next;
                                if (chip_cnt_q == LAST_CHIP) begin
                                    chip_cnt_q   <= '0;
                                    code_epoch_q <= 1'b1;
                                    if (epoch_inc == EPOCH_MAX) begin
                                        epoch_cnt_q <= '0;
                                        data_q      <= bus.nav_bit;
                                        data_req_q  <= 1'b1;
                                    end else begin
                                        epoch_cnt_q <= epoch_inc;
                                    end
                                end else begin
                                    chip_cnt_q <= chip_cnt_q + 10'd1;
                                end
                            end
                            if (burst_end) begin
                                state_q   <= StIdle;
                                busy_q    <= 1'b0;
                                adc_clk_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.adc_clk      = adc_clk_q;
    assign bus.i_sample     = i_q;
    assign bus.q_sample     = q_q;
    assign bus.busy         = busy_q;
    assign bus.code_epoch   = code_epoch_q;
    assign bus.data_req     = data_req_q;
    assign bus.sample_count = sample_count_q;

endmodule
